// File: rtl/hub75_fb_loader.sv
// Raster pixel stream to hub75 frame-buffer loader: fills the line buffer, commits lines, then requests a frame swap.
// Optional saturating abort counter (err_cnt/err_clr) is built when HUB75_FB_LOADER_ERRCNT_EN is defined.
module hub75_fb_loader #(
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned N_ROWS      = 32,
  parameter int unsigned N_COLS      = 64,
  parameter int unsigned BITDEPTH    = 24,
  parameter int unsigned LOG_N_BANKS = $clog2(N_BANKS),
  parameter int unsigned LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int unsigned LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BITDEPTH-1:0]    in_data,
  input  logic                   in_sof,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LOG_N_BANKS-1:0] fbw_bank_addr,
  output logic [LOG_N_ROWS-1:0]  fbw_row_addr,
  output logic                   fbw_row_store,
  input  logic                   fbw_row_rdy,
  output logic                   fbw_row_swap,
  output logic [BITDEPTH-1:0]    fbw_data,
  output logic [LOG_N_COLS-1:0]  fbw_col_addr,
  output logic                   fbw_wren,
  output logic                   frame_swap,
  input  logic                   frame_rdy,
`ifdef HUB75_FB_LOADER_ERRCNT_EN
  output logic                   busy,
  input  logic                   err_clr,
  output logic [7:0]             err_cnt
`else
  output logic                   busy
`endif
);

  localparam int unsigned LW        = LOG_N_BANKS + LOG_N_ROWS;
  localparam int unsigned LAST_LINE = N_BANKS * N_ROWS - 1;
  localparam int unsigned LAST_COL  = N_COLS - 1;

  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    FILL   = 3'd1,
    COMMIT = 3'd2,
    DRAIN  = 3'd3,
    FSWAP  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [LOG_N_COLS-1:0]   col_q, col_d;
  logic [LW-1:0]           line_q, line_d;
  logic                    in_ready_q, in_ready_d;
  logic                    wren_q, wren_d;
  logic [BITDEPTH-1:0]     data_q, data_d;
  logic [LOG_N_COLS-1:0]   col_addr_q, col_addr_d;
  logic                    commit_q, commit_d;
  logic [LOG_N_BANKS-1:0]  bank_q, bank_d;
  logic [LOG_N_ROWS-1:0]   row_q, row_d;
  logic                    fswap_q, fswap_d;
  logic                    busy_q, busy_d;
  logic                    accept_c;
  logic                    abort_c;

  assign accept_c = in_valid & in_ready_q;
  // A SOF anywhere but the very first pixel of the frame restarts the frame at line 0.
  assign abort_c  = accept_c & in_sof & (state_q == FILL) &
                    ((col_q != '0) | (line_q != '0));

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    wren_d     = 1'b0;
    data_d     = data_q;
    col_addr_d = col_addr_q;
    commit_d   = 1'b0;
    bank_d     = bank_q;
    row_d      = row_q;
    fswap_d    = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      SYNC: begin
        if (accept_c && in_sof) begin
          wren_d     = 1'b1;
          data_d     = in_data;
          col_addr_d = '0;
          col_d      = LOG_N_COLS'(1);
          line_d     = '0;
          busy_d     = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (accept_c) begin
          wren_d = 1'b1;
          data_d = in_data;
          if (abort_c) begin
            line_d     = '0;
            col_addr_d = '0;
            col_d      = LOG_N_COLS'(1);
          end else begin
            col_addr_d = col_q;
            if (col_q == LOG_N_COLS'(LAST_COL)) begin
              col_d   = '0;
              state_d = COMMIT;
            end else begin
              col_d = LOG_N_COLS'(col_q + 1'b1);
            end
          end
        end
      end
      COMMIT: begin
        if (fbw_row_rdy) begin
          commit_d = 1'b1;
          bank_d   = line_q[LW-1:LOG_N_ROWS];
          row_d    = line_q[LOG_N_ROWS-1:0];
          if (line_q == LW'(LAST_LINE)) begin
            line_d  = '0;
            state_d = DRAIN;
          end else begin
            line_d  = LW'(line_q + 1'b1);
            state_d = FILL;
          end
        end
      end
      DRAIN: begin
        if (fbw_row_rdy) state_d = FSWAP;
      end
      FSWAP: begin
        if (frame_rdy) begin
          fswap_d = 1'b1;
          busy_d  = 1'b0;
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase

    // Ready is registered, so it follows the state we are about to enter.
    in_ready_d = (state_d == SYNC) || (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SYNC;
      col_q      <= '0;
      line_q     <= '0;
      in_ready_q <= 1'b0;
      wren_q     <= 1'b0;
      data_q     <= '0;
      col_addr_q <= '0;
      commit_q   <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      fswap_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      line_q     <= line_d;
      in_ready_q <= in_ready_d;
      wren_q     <= wren_d;
      data_q     <= data_d;
      col_addr_q <= col_addr_d;
      commit_q   <= commit_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      fswap_q    <= fswap_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign fbw_wren      = wren_q;
  assign fbw_data      = data_q;
  assign fbw_col_addr  = col_addr_q;
  assign fbw_row_store = commit_q;
  assign fbw_row_swap  = commit_q;
  assign fbw_bank_addr = bank_q;
  assign fbw_row_addr  = row_q;
  assign frame_swap    = fswap_q;
  assign busy          = busy_q;

`ifdef HUB75_FB_LOADER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating abort counter; clear wins over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (abort_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = 8'(err_cnt_q + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
